// File: rtl/ibex_l2_rf_access_ctrl.sv
// Serialises one write-back / operand-A / operand-B bundle per instruction onto the
// single L2 register-file port, stalling ID until both operands are returned together.
//   state | meaning
//   IDLE  | ready for a bundle
//   WR    | write-back driven onto L2
//   RD_A  | operand A read from L2
//   RD_B  | operand B read from L2
//   RESP  | operands presented, resp_valid_o pulse
module ibex_l2_rf_access_ctrl #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned L1Base    = 12,
    parameter int unsigned L1Num     = 4,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 wr_en_i,
    input  logic [4:0]           wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic                 rd_a_en_i,
    input  logic [4:0]           rd_a_addr_i,
    input  logic                 rd_b_en_i,
    input  logic [4:0]           rd_b_addr_i,
    input  logic                 flush_i,
    output logic [4:0]           l2_addr_o,
    output logic                 l2_we_o,
    output logic [DataWidth-1:0] l2_wdata_o,
    input  logic [DataWidth-1:0] l2_rdata_i,
    output logic                 resp_valid_o,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic [DataWidth-1:0] rdata_b_o,
    output logic                 stall_o,
    output logic [CntWidth-1:0]  stall_cnt_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD_A = 3'd2,
        RD_B = 3'd3,
        RESP = 3'd4
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    logic                 r_wr_need;
    logic                 r_a_need;
    logic                 r_b_need;
    logic                 r_b_dup;
    logic [4:0]           r_wr_addr;
    logic [4:0]           r_a_addr;
    logic [4:0]           r_b_addr;
    logic [DataWidth-1:0] r_wr_data;
    logic [DataWidth-1:0] r_buf_a;
    logic [DataWidth-1:0] r_buf_b;
    logic [CntWidth-1:0]  r_stall_cnt;

    logic w_accept;
    logic w_wr_need;
    logic w_a_need;
    logic w_b_raw;
    logic w_b_dup;
    logic w_b_need;

    // x0 and the L1-resident window never reach L2.
    function automatic logic f_needed(input logic en, input logic [4:0] addr);
        logic [31:0] a32;
        a32 = {27'd0, addr};
        return en && (addr != 5'd0) && !((a32 >= L1Base) && (a32 < (L1Base + L1Num)));
    endfunction

    assign w_accept  = req_valid_i && !flush_i && (r_state == IDLE);
    assign w_wr_need = f_needed(wr_en_i, wr_addr_i);
    assign w_a_need  = f_needed(rd_a_en_i, rd_a_addr_i);
    assign w_b_raw   = f_needed(rd_b_en_i, rd_b_addr_i);
    assign w_b_dup   = w_a_need && w_b_raw && (rd_a_addr_i == rd_b_addr_i);
    assign w_b_need  = w_b_raw && !w_b_dup;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_wr_need   <= 1'b0;
            r_a_need    <= 1'b0;
            r_b_need    <= 1'b0;
            r_b_dup     <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_a_addr    <= 5'd0;
            r_b_addr    <= 5'd0;
            r_wr_data   <= '0;
            r_buf_a     <= '0;
            r_buf_b     <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_wr_need <= w_wr_need;
                r_a_need  <= w_a_need;
                r_b_need  <= w_b_need;
                r_b_dup   <= w_b_dup;
                r_wr_addr <= wr_addr_i;
                r_a_addr  <= rd_a_addr_i;
                r_b_addr  <= rd_b_addr_i;
                r_wr_data <= wr_data_i;
                r_buf_a   <= '0;
                r_buf_b   <= '0;
            end
            if (r_state == RD_A) begin
                r_buf_a <= l2_rdata_i;
                if (r_b_dup) begin
                    r_buf_b <= l2_rdata_i;
                end
            end
            if (r_state == RD_B) begin
                r_buf_b <= l2_rdata_i;
            end
            if (stall_o && (r_stall_cnt != {CntWidth{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CntWidth'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req_ready_o  = 1'b0;
        l2_we_o      = 1'b0;
        l2_addr_o    = 5'd0;
        l2_wdata_o   = '0;
        resp_valid_o = 1'b0;
        stall_o      = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (w_accept) begin
                    if (w_wr_need)     w_state_nxt = WR;
                    else if (w_a_need) w_state_nxt = RD_A;
                    else if (w_b_need) w_state_nxt = RD_B;
                    else               w_state_nxt = RESP;
                end
            end
            WR: begin
                stall_o    = 1'b1;
                l2_we_o    = 1'b1;
                l2_addr_o  = r_wr_addr;
                l2_wdata_o = r_wr_data;
                if (r_a_need)      w_state_nxt = RD_A;
                else if (r_b_need) w_state_nxt = RD_B;
                else               w_state_nxt = RESP;
            end
            RD_A: begin
                stall_o     = 1'b1;
                l2_addr_o   = r_a_addr;
                w_state_nxt = r_b_need ? RD_B : RESP;
            end
            RD_B: begin
                stall_o     = 1'b1;
                l2_addr_o   = r_b_addr;
                w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // A flush in WR still lets the write commit since l2_we_o is left as is.
        if (flush_i) begin
            w_state_nxt  = IDLE;
            resp_valid_o = 1'b0;
        end
    end

    assign rdata_a_o   = r_buf_a;
    assign rdata_b_o   = r_buf_b;
    assign stall_cnt_o = r_stall_cnt;

endmodule
